heart_collect_responder: RTL and testbench

Consumer end of the heart bitmap interface. It takes the registered `drawingRequest` and `HitEdgeCode` from the heart bitmap, plus the player's `drawingRequest`, and detects player/heart overlap within a frame. At the next frame boundary it turns that overlap into a single per-frame "heart collected" event. It also owns the heart's visibility, a respawn cooldown counted in frames, and a saturating collected-hearts counter used by the game controller and score display.

---
 rtl/heart_collect_pkg.sv | 15 +
 rtl/heart_collect_if.sv | 28 ++
 rtl/heart_collect_responder_frame_cooldown_timer.sv | 30 +++
 rtl/heart_collect_responder.sv | 99 +++++++++
 tb/tb_heart_collect_responder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/heart_collect_pkg.sv
// Shared types and constants for the heart collection responder.
package heart_collect_pkg;

  typedef enum logic [1:0] {ARMED, HIT_SEEN, COOLDOWN} heart_collect_state_t;

  // Bit positions inside a {Left, Top, Right, Bottom} hit edge code.
  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  localparam int unsigned EDGE_W  = 4;
  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/heart_collect_if.sv
// Heart bitmap / player overlap inputs and collection status outputs.
interface heart_collect_if #(
  parameter int unsigned COUNT_W = 3
);
  import heart_collect_pkg::*;

  logic               startOfFrame;
  logic               playerDrawingRequest;
  logic               heartDrawingRequest;
  logic [EDGE_W-1:0]  heartHitEdgeCode;

  logic               collected;
  logic [EDGE_W-1:0]  collectEdgeCode;
  logic [COUNT_W-1:0] heartCount;
  logic               heartVisible;
  logic               cooldownActive;

  modport master (
    output startOfFrame, playerDrawingRequest, heartDrawingRequest, heartHitEdgeCode,
    input  collected, collectEdgeCode, heartCount, heartVisible, cooldownActive
  );

  modport slave (
    input  startOfFrame, playerDrawingRequest, heartDrawingRequest, heartHitEdgeCode,
    output collected, collectEdgeCode, heartCount, heartVisible, cooldownActive
  );

endinterface

// File: rtl/heart_collect_responder_frame_cooldown_timer.sv
// Frame-counting down-timer for respawnable objects: load, then one decrement per frame.
module frame_cooldown_timer
  import heart_collect_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadValue,
  input  logic               startOfFrame,
  output logic               expire,
  output logic               busy
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (startOfFrame && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign busy   = (count != '0);
  // Decoded in the frame-start cycle itself so the owner can react on the same edge.
  assign expire = startOfFrame && !load && (count == TIMER_W'(1));

endmodule

// File: rtl/heart_collect_responder.sv
// Detects player/heart overlap, commits one collection per frame, runs respawn cooldown.
module heart_collect_responder
  import heart_collect_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 16,
  parameter int unsigned MAX_HEARTS      = 5,
  parameter int unsigned COUNT_W         = 3
) (
  input  logic            clk,
  input  logic            resetN,
  heart_collect_if.slave  bus
);

  heart_collect_state_t state;

  logic               player_d;
  logic               heart_d;
  logic               overlap;
  logic               collected_q;
  logic [EDGE_W-1:0]  edge_q;
  logic [COUNT_W-1:0] count_q;
  logic               visible_q;
  logic               cooldown_q;
  logic               timer_load;
  logic               timer_expire;
  logic               timer_busy;

  // Delay the drawing requests so they line up with the lagging edge code.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      player_d <= 1'b0;
      heart_d  <= 1'b0;
    end else begin
      player_d <= bus.playerDrawingRequest;
      heart_d  <= bus.heartDrawingRequest;
    end
  end

  assign overlap    = player_d & heart_d & visible_q;
  assign timer_load = (state == HIT_SEEN) && bus.startOfFrame;

  frame_cooldown_timer u_timer (
    .clk          (clk),
    .resetN       (resetN),
    .load         (timer_load),
    .loadValue    (TIMER_W'(COOLDOWN_FRAMES)),
    .startOfFrame (bus.startOfFrame),
    .expire       (timer_expire),
    .busy         (timer_busy)
  );

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state       <= ARMED;
      collected_q <= 1'b0;
      edge_q      <= '0;
      count_q     <= '0;
      visible_q   <= 1'b1;
      cooldown_q  <= 1'b0;
    end else begin
      collected_q <= 1'b0;
      case (state)
        ARMED: begin
          if (overlap) begin
            edge_q <= bus.heartHitEdgeCode;
            state  <= HIT_SEEN;
          end
        end
        HIT_SEEN: begin
          if (bus.startOfFrame) begin
            collected_q <= 1'b1;
            if (count_q < COUNT_W'(MAX_HEARTS)) begin
              count_q <= count_q + COUNT_W'(1);
            end
            visible_q  <= 1'b0;
            cooldown_q <= 1'b1;
            state      <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          // An idle timer here can only mean a lost load; re-arm rather than hide forever.
          if (timer_expire || !timer_busy) begin
            visible_q  <= 1'b1;
            cooldown_q <= 1'b0;
            state      <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  assign bus.collected       = collected_q;
  assign bus.collectEdgeCode = edge_q;
  assign bus.heartCount      = count_q;
  assign bus.heartVisible    = visible_q;
  assign bus.cooldownActive  = cooldown_q;

endmodule

// File: tb/tb_heart_collect_responder.sv
// Scoreboard bench: frame-level reference model feeds expectation queues, negedge monitor checks.
module tb_heart_collect_responder;
  import heart_collect_pkg::*;

  localparam int unsigned CD   = 2;
  localparam int unsigned MAXH = 5;
  localparam int unsigned CW   = 3;
  localparam int          L    = 12;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  heart_collect_if #(.COUNT_W(CW)) bus ();

  heart_collect_responder #(
    .COOLDOWN_FRAMES (CD),
    .MAX_HEARTS      (MAXH),
    .COUNT_W         (CW)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    int         cyc;
    logic [9:0] st;
  } status_t;

  typedef struct {
    int          cyc;
    logic [3:0]  ecode;
    int unsigned count;
  } pulse_t;

  status_t sq[$];
  pulse_t  pq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned exp_pulses = 0;
  int unsigned obs_pulses = 0;

  // Reference model: hit pending flag, frames still hidden, latched edge, hearts held.
  bit          m_hit;
  int unsigned m_hidden;
  logic [3:0]  m_edge;
  int unsigned m_count;
  bit          prev_p, prev_h;
  logic [3:0]  prev_e;

  logic [3:0]  e_lt, e_rb;

  function automatic logic [9:0] pack_st(logic c, logic [3:0] e, logic [2:0] n, logic v, logic d);
    return {c, e, n, v, d};
  endfunction

  function void check(string name, int unsigned act, int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endfunction

  // One pixel cycle: drive inputs, advance the model, queue what the DUT shows next cycle.
  task automatic step(input bit sof, input bit p, input bit h, input logic [3:0] e);
    bit ov;
    bit commit;
    bus.startOfFrame         = sof;
    bus.playerDrawingRequest = p;
    bus.heartDrawingRequest  = h;
    bus.heartHitEdgeCode     = prev_e;
    ov     = prev_p && prev_h && (m_hidden == 0);
    commit = 1'b0;
    if (m_hidden != 0) begin
      if (sof) m_hidden--;
    end else if (m_hit) begin
      if (sof) begin
        commit = 1'b1;
        m_hit  = 1'b0;
        if (m_count < MAXH) m_count++;
        m_hidden = CD;
        exp_pulses++;
        pq.push_back('{cyc + 1, m_edge, m_count});
      end
    end else if (ov) begin
      m_hit  = 1'b1;
      m_edge = prev_e;
    end
    sq.push_back('{cyc + 1, pack_st(commit, m_edge, 3'(m_count), m_hidden == 0, m_hidden != 0)});
    prev_p = p;
    prev_h = h;
    prev_e = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    resetN = 1'b1;
    bus.startOfFrame         = 1'b0;
    bus.playerDrawingRequest = 1'b0;
    bus.heartDrawingRequest  = 1'b0;
    bus.heartHitEdgeCode     = 4'h0;
    exp_pulses = exp_pulses - pq.size();
    sq.delete();
    pq.delete();
    m_hit = 0; m_hidden = 0; m_edge = 4'h0; m_count = 0;
    prev_p = 0; prev_h = 0; prev_e = 4'h0;
    for (int i = 0; i < n; i++) begin
      sq.push_back('{cyc, pack_st(1'b0, 4'h0, 3'd0, 1'b1, 1'b0)});
      @(posedge clk);
      #1;
    end
    resetN = 1'b0;
    sq.push_back('{cyc, pack_st(1'b0, 4'h0, 3'd0, 1'b1, 1'b0)});
  endtask

  // Frame with overlap on pixels lo..hi (lo<0 means none); first overlap pixel carries e_first.
  task automatic frame_dir(input int lo, input int hi, input logic [3:0] e_first, input logic [3:0] e_rest);
    bit on;
    for (int i = 0; i < L; i++) begin
      on = (lo >= 0) && (i >= lo) && (i <= hi);
      step(i == 0, on, on, (i == lo) ? e_first : e_rest);
    end
  endtask

  task automatic frame_rand(input int unsigned pct);
    for (int i = 0; i < L; i++)
      step(i == 0, $urandom_range(99) < pct, $urandom_range(99) < pct, 4'($urandom));
  endtask

  always @(negedge clk) begin
    status_t s;
    pulse_t  p;
    while (sq.size() != 0 && sq[0].cyc < cyc) void'(sq.pop_front());
    if (sq.size() != 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      check("status{col,edge,cnt,vis,cd}",
            32'(pack_st(bus.collected, bus.collectEdgeCode, bus.heartCount,
                        bus.heartVisible, bus.cooldownActive)), 32'(s.st));
    end
    if (bus.collected === 1'b1) begin
      obs_pulses++;
      check("pulse_was_expected", 32'(pq.size() != 0), 32'(1));
      if (pq.size() != 0) begin
        p = pq.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(p.cyc));
        check("pulse_count", 32'(bus.heartCount), p.count);
        check("pulse_edge", 32'(bus.collectEdgeCode), 32'(p.ecode));
      end
    end
  end

  initial begin
    int unsigned base;
    int lo;
    e_lt = 4'h0; e_lt[EDGE_LEFT]  = 1'b1; e_lt[EDGE_TOP]    = 1'b1;
    e_rb = 4'h0; e_rb[EDGE_RIGHT] = 1'b1; e_rb[EDGE_BOTTOM] = 1'b1;
    bus.startOfFrame         = 1'b0;
    bus.playerDrawingRequest = 1'b0;
    bus.heartDrawingRequest  = 1'b0;
    bus.heartHitEdgeCode     = 4'h0;
    @(posedge clk);
    #1;

    // Reset and idle frames.
    do_reset(3);
    for (int f = 0; f < 3; f++) frame_dir(-1, -1, 4'h0, 4'h0);
    check("idle_visible", 32'(bus.heartVisible), 32'(1));
    check("idle_count", 32'(bus.heartCount), 32'(0));
    check("idle_edge", 32'(bus.collectEdgeCode), 32'(0));
    check("idle_pulses", obs_pulses, 32'(0));

    // Single hit: first overlap pixel wins.
    frame_dir(3, 6, e_lt, e_rb);
    check("first_pixel_edge", 32'(bus.collectEdgeCode), 32'(e_lt));
    // Commit frame and second cooldown frame, both full of overlap.
    frame_dir(0, L - 1, e_rb, e_rb);
    check("commit_count", 32'(bus.heartCount), 32'(1));
    check("commit_hidden", 32'(bus.heartVisible), 32'(0));
    check("commit_cooldown", 32'(bus.cooldownActive), 32'(1));
    frame_dir(0, L - 1, e_rb, e_rb);
    check("cooldown_no_pulse", obs_pulses, 32'(1));

    // Overlap landing on the frame-start cycle while armed.
    frame_dir(L - 1, L - 1, 4'hA, 4'hA);
    frame_dir(-1, -1, 4'h0, 4'h0);
    check("simultaneous_no_pulse", obs_pulses, 32'(1));
    check("simultaneous_edge", 32'(bus.collectEdgeCode), 32'(4'hA));
    frame_dir(-1, -1, 4'h0, 4'h0);
    check("simultaneous_late_pulse", obs_pulses, 32'(2));

    // Reset while a hit is pending.
    frame_dir(-1, -1, 4'h0, 4'h0);
    frame_dir(3, 4, 4'h5, 4'h6);
    do_reset(2);
    frame_dir(-1, -1, 4'h0, 4'h0);
    check("midreset_pulses", obs_pulses, 32'(2));
    check("midreset_count", 32'(bus.heartCount), 32'(0));
    check("midreset_visible", 32'(bus.heartVisible), 32'(1));

    // Seven collections against a five-heart ceiling.
    base = obs_pulses;
    for (int k = 0; k < 7; k++) begin
      lo = int'($urandom_range(0, L - 3));
      frame_dir(lo, lo + int'($urandom_range(0, 32'(L - 2 - lo))), 4'($urandom), 4'($urandom));
      frame_dir(-1, -1, 4'h0, 4'h0);
      frame_dir(-1, -1, 4'h0, 4'h0);
    end
    check("saturation_pulses", obs_pulses - base, 32'(7));
    check("saturation_count", 32'(bus.heartCount), 32'(MAXH));

    // Random traffic.
    for (int f = 0; f < 40; f++) frame_rand(30);
    for (int f = 0; f < 4; f++) frame_dir(-1, -1, 4'h0, 4'h0);
    check("pulse_total", obs_pulses, exp_pulses);
    check("pulse_queue_drained", 32'(pq.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
